// File: rtl/crt_status_sched.sv
// Purpose : shares one serial status pin between three requesters, a cookie slot and LFSR noise.
// Latency : ack/sframe/cookie_slot one clk after the load cycle; first bit on sout one clk later.
// Backpress: requesters hold req until ack; requests are only sampled at packet boundaries.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req[2:0]            per-requester packet request, held until ack
//   data0..data2        requester status bytes, captured in the grant cycle
//   ack[2:0]            one-cycle grant pulse (registered)
//   sout                serial output, MSB first, each bit held BIT_DIV clks
//   sframe              high for the whole of a requester-data packet
//   cookie_slot         high for the whole of the cookie packet
//   bit_ena             one-cycle pulse on the last clk of each bit slot
//   pkt_cnt             index of the packet currently being sent
module crt_status_sched #(
    parameter int unsigned BIT_DIV    = 16,
    parameter logic [11:0] COOKIE_PKT = 12'hB68,
    parameter logic [7:0]  COOKIE     = 8'hB2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic [7:0]  data2,
    output logic [2:0]  ack,
    output logic        sout,
    output logic        sframe,
    output logic        cookie_slot,
    output logic        bit_ena,
    output logic [11:0] pkt_cnt
);

    localparam int DW = $clog2(BIT_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    logic [DW-1:0] div;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [15:0]   lfsr;
    logic [1:0]    rr_ptr;
    logic          start;

    logic          load;
    logic [11:0]   pkt_next;
    logic          lfsr_fb;
    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic [7:0]    gnt_dat;

    assign bit_ena  = (div == DIV_LAST);
    assign load     = start | (bit_ena & (bit_idx == 3'd7));
    // The very first packet after reset keeps index 0; later loads advance it.
    assign pkt_next = start ? pkt_cnt : pkt_cnt + 12'd1;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Round-robin pick: first requester found scanning upward from rr_ptr.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 2'd0;
        case (rr_ptr)
            2'd1:    gnt_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    gnt_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: gnt_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        gnt_dat = data0;
        case (gnt_idx)
            2'd1:    gnt_dat = data1;
            2'd2:    gnt_dat = data2;
            default: gnt_dat = data0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            bit_idx     <= 3'd0;
            pkt_cnt     <= 12'd0;
            shreg       <= 8'd0;
            sout        <= 1'b0;
            sframe      <= 1'b0;
            cookie_slot <= 1'b0;
            ack         <= 3'b000;
            lfsr        <= LFSR_SEED;
            rr_ptr      <= 2'd0;
            start       <= 1'b1;
        end else begin
            start <= 1'b0;
            sout  <= shreg[7];
            ack   <= 3'b000;

            // Hold div at 0 across the start load so packet 0 gets full-length bit slots.
            if (start || bit_ena) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end

            if (bit_ena) begin
                bit_idx <= bit_idx + 3'd1;
                lfsr    <= {lfsr[14:0], lfsr_fb};
            end

            if (load) begin
                pkt_cnt <= pkt_next;
                if (pkt_next == COOKIE_PKT) begin
                    // Cookie outranks requesters; rr_ptr and pending reqs are left alone.
                    shreg       <= COOKIE;
                    cookie_slot <= 1'b1;
                    sframe      <= 1'b0;
                end else if (gnt_vld) begin
                    ack         <= 3'b001 << gnt_idx;
                    shreg       <= gnt_dat;
                    sframe      <= 1'b1;
                    cookie_slot <= 1'b0;
                    rr_ptr      <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
                end else begin
                    shreg       <= lfsr[7:0];
                    sframe      <= 1'b0;
                    cookie_slot <= 1'b0;
                end
            end else if (bit_ena) begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_crt_status_sched.sv
// Purpose : directed bench for crt_status_sched, two instances (BIT_DIV=4 and BIT_DIV=2/COOKIE_PKT=3).
// Latency : checks every clk of each packet against a bench-side timing and LFSR model.
// Backpress: requesters are modelled by the stimulus table (req held or dropped per packet).
module tb_crt_status_sched;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic [2:0]  req;
    logic [7:0]  data0, data1, data2;
    logic [2:0]  ack_a, ack_b;
    logic        sout_a, sout_b, sframe_a, sframe_b, ck_a, ck_b, be_a, be_b;
    logic [11:0] pc_a, pc_b;
    logic        sel;

    logic [2:0]  o_ack;
    logic        o_sout, o_sframe, o_cookie, o_bit_ena;
    logic [11:0] o_pkt_cnt;

    always #5 clk = ~clk;

    crt_status_sched #(.BIT_DIV(4)) u_a (
        .clk(clk), .reset(reset_a), .req(req), .data0(data0), .data1(data1), .data2(data2),
        .ack(ack_a), .sout(sout_a), .sframe(sframe_a), .cookie_slot(ck_a), .bit_ena(be_a),
        .pkt_cnt(pc_a)
    );

    crt_status_sched #(.BIT_DIV(2), .COOKIE_PKT(12'd3)) u_b (
        .clk(clk), .reset(reset_b), .req(req), .data0(data0), .data1(data1), .data2(data2),
        .ack(ack_b), .sout(sout_b), .sframe(sframe_b), .cookie_slot(ck_b), .bit_ena(be_b),
        .pkt_cnt(pc_b)
    );

    assign o_ack     = sel ? ack_b    : ack_a;
    assign o_sout    = sel ? sout_b   : sout_a;
    assign o_sframe  = sel ? sframe_b : sframe_a;
    assign o_cookie  = sel ? ck_b     : ck_a;
    assign o_bit_ena = sel ? be_b     : be_a;
    assign o_pkt_cnt = sel ? pc_b     : pc_a;

    typedef struct {
        logic [2:0] r;
        logic [7:0] d0, d1, d2;
        logic [2:0] pulse;
        logic [2:0] e_ack;
        logic       e_sfr;
        logic       e_ck;
        logic       e_noise;
        logic [7:0] e_byte;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          bdiv;
    logic        first;
    logic [11:0] exp_p;
    logic [15:0] m_lfsr;

    localparam logic [15:0] SEED = 16'hACE1;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic vec_t mk(input logic [2:0] r, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [2:0] pulse,
                                input logic [2:0] e_ack, input logic e_sfr, input logic e_ck,
                                input logic e_noise, input logic [7:0] e_byte);
        vec_t v;
        v.r = r; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.pulse = pulse;
        v.e_ack = e_ack; v.e_sfr = e_sfr; v.e_ck = e_ck; v.e_noise = e_noise; v.e_byte = e_byte;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered at the negedge just before a load edge; leaves at the negedge before the next one.
    task automatic do_packet(input vec_t v, input string nm);
        logic [7:0] exp_b;
        logic [7:0] got;
        int         bad_hold;
        int         bad_be;
        req   = v.r;
        data0 = v.d0;
        data1 = v.d1;
        data2 = v.d2;
        exp_b = v.e_noise ? m_lfsr[7:0] : v.e_byte;
        got = 8'h00;
        bad_hold = 0;
        bad_be = 0;
        @(posedge clk);
        if (!first) m_lfsr = lstep(m_lfsr);
        first = 1'b0;
        @(negedge clk);
        check({nm, " ack"},     {29'd0, o_ack},     {29'd0, v.e_ack});
        check({nm, " sframe"},  {31'd0, o_sframe},  {31'd0, v.e_sfr});
        check({nm, " cookie"},  {31'd0, o_cookie},  {31'd0, v.e_ck});
        check({nm, " pkt_cnt"}, {20'd0, o_pkt_cnt}, {20'd0, exp_p});
        if (o_bit_ena !== 1'b0) bad_be++;
        for (int k = 1; k < 8 * bdiv; k++) begin
            @(posedge clk);
            if (k % bdiv == 0) m_lfsr = lstep(m_lfsr);
            @(negedge clk);
            if (o_ack !== 3'b000 || o_sframe !== v.e_sfr || o_cookie !== v.e_ck ||
                o_pkt_cnt !== exp_p) bad_hold++;
            if (o_bit_ena !== ((k % bdiv) == (bdiv - 1))) bad_be++;
            if (k % bdiv == 1) got[7 - k / bdiv] = o_sout;
            if (k == 2 && v.pulse != 3'b000) req = v.pulse;
        end
        check({nm, " byte"},    {24'd0, got}, {24'd0, exp_b});
        check({nm, " hold"},    bad_hold, 0);
        check({nm, " bit_ena"}, bad_be, 0);
        exp_p = exp_p + 12'd1;
    endtask

    task automatic check_zero(input string nm);
        check({nm, " ack"},     {29'd0, o_ack},     32'd0);
        check({nm, " sout"},    {31'd0, o_sout},    32'd0);
        check({nm, " sframe"},  {31'd0, o_sframe},  32'd0);
        check({nm, " cookie"},  {31'd0, o_cookie},  32'd0);
        check({nm, " bit_ena"}, {31'd0, o_bit_ena}, 32'd0);
        check({nm, " pkt_cnt"}, {20'd0, o_pkt_cnt}, 32'd0);
    endtask

    vec_t va[12];
    vec_t vb[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic ck;
        // Instance A, BIT_DIV=4. Entries 3.. run after a mid-packet reset (rr_ptr back to 0).
        va[0]  = mk(3'b001, 8'hA5, 8'h00, 8'h00, 3'b000, 3'b001, 1, 0, 0, 8'hA5);
        va[1]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 0, 0, 1, 8'h00);
        va[2]  = mk(3'b010, 8'h00, 8'h5A, 8'h00, 3'b000, 3'b010, 1, 0, 0, 8'h5A);
        va[3]  = mk(3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b001, 1, 0, 0, 8'h11);
        va[4]  = mk(3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b010, 1, 0, 0, 8'h22);
        va[5]  = mk(3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b100, 1, 0, 0, 8'h33);
        va[6]  = mk(3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b001, 1, 0, 0, 8'h11);
        va[7]  = mk(3'b000, 8'h11, 8'h22, 8'h33, 3'b100, 3'b000, 0, 0, 1, 8'h00);
        va[8]  = mk(3'b000, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 0, 0, 1, 8'h00);
        va[9]  = mk(3'b111, 8'h11, 8'h22, 8'h33, 3'b000, 3'b010, 1, 0, 0, 8'h22);
        va[10] = mk(3'b101, 8'h11, 8'h22, 8'h33, 3'b000, 3'b100, 1, 0, 0, 8'h33);
        va[11] = mk(3'b101, 8'h11, 8'h22, 8'h33, 3'b000, 3'b001, 1, 0, 0, 8'h11);
        // Instance B, BIT_DIV=2, COOKIE_PKT=3: req rises in packet 2, cookie wins packet 3.
        vb[0]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 0, 0, 1, 8'h00);
        vb[1]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 0, 0, 1, 8'h00);
        vb[2]  = mk(3'b000, 8'hC3, 8'h00, 8'h00, 3'b001, 3'b000, 0, 0, 1, 8'h00);
        vb[3]  = mk(3'b001, 8'hC3, 8'h00, 8'h00, 3'b000, 3'b000, 0, 1, 0, 8'hB2);
        vb[4]  = mk(3'b001, 8'hC3, 8'h00, 8'h00, 3'b000, 3'b001, 1, 0, 0, 8'hC3);

        sel = 1'b0;
        bdiv = 4;
        reset_a = 1'b1;
        reset_b = 1'b1;
        req = 3'b000;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("A reset");

        @(negedge clk);
        reset_a = 1'b0;
        first = 1'b1; exp_p = 12'd0; m_lfsr = SEED;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                // Start packet 3 with requester 2, then abort it with reset mid-packet.
                req = 3'b100; data2 = 8'hFF;
                @(posedge clk);
                @(negedge clk);
                check("A pre-reset ack", {29'd0, o_ack}, 32'd4);
                check("A pre-reset pkt_cnt", {20'd0, o_pkt_cnt}, 32'd3);
                repeat (5) @(negedge clk);
                check("A pre-reset sout", {31'd0, o_sout}, 32'd1);
                #2;
                reset_a = 1'b1;
                #1;
                check_zero("A mid-packet reset");
                repeat (2) @(negedge clk);
                req = 3'b111;
                reset_a = 1'b0;
                first = 1'b1; exp_p = 12'd0; m_lfsr = SEED;
            end
            do_packet(va[i], $sformatf("A%0d", i));
        end

        // Instance B: cookie, then 4097 request-free packets across the pkt_cnt wrap.
        @(negedge clk);
        reset_a = 1'b1;
        sel = 1'b1;
        bdiv = 2;
        req = 3'b000;
        @(negedge clk);
        reset_b = 1'b0;
        first = 1'b1; exp_p = 12'd0; m_lfsr = SEED;
        for (int i = 0; i < 5; i++) begin
            do_packet(vb[i], $sformatf("B%0d", i));
        end
        for (int i = 0; i < 4097; i++) begin
            ck = (exp_p == 12'd3);
            v = mk(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 0, ck, !ck, ck ? 8'hB2 : 8'h00);
            do_packet(v, $sformatf("N%0d", i));
        end
        check("B wrap pkt_cnt", {20'd0, o_pkt_cnt}, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
